// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   state_t / IDLE, ISSUE, WAIT, DONE : arbiter FSM encoding
//   OWNER_IF / OWNER_D                : owner encoding (also the RR pointer encoding)
//   MEM_LAT_MAX                       : largest memory latency the 3-bit counter supports
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    localparam int unsigned MEM_LAT_MAX = 7;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory port of mem_port_arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants, rvalids, rdata, memory strobes)
//   master : environment view (control unit + memory model)
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Memory latency counter for mem_port_arbiter: 3-bit loadable down-counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (takes priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement (saturates at 0)
//   one_o       : count equals 1, i.e. the current cycle is the last wait cycle
module mem_arb_lat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       one_o
);
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one_o = (cnt_q == 3'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch (IF)
// and data load/store (D). Serialises accesses: IDLE -> ISSUE -> WAIT -> DONE,
// one access per MEM_LAT+2 cycles back to back.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (fetch port, data port, memory port)
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..7, issue cycle to mem_rdata valid).
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise
// D wins every tie (fixed priority, IF may starve).
// All outputs are decoded from registered state; no req-to-output path exists.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [2:0] LAT = (MEM_LAT == 0)           ? 3'd1 :
                                 (MEM_LAT > MEM_LAT_MAX)  ? 3'(MEM_LAT_MAX) :
                                                            3'(MEM_LAT);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick_d;
    logic              lat_one;
    logic              if_done, d_done;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // Tie goes to whoever was not the last owner.
    assign pick_d = bus.d_req && (!bus.if_req || (last_q == OWNER_IF));

    always_comb begin
        last_d = last_q;
        if (state_q == ISSUE) begin
            last_d = owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWNER_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick_d = bus.d_req;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d = ISSUE;
                    if (pick_d) begin
                        owner_d = OWNER_D;
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_we ? bus.d_wdata : '0;
                    end else begin
                        owner_d = OWNER_IF;
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_one) begin
                    state_d = DONE;
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWNER_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    mem_arb_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == ISSUE),
        .load_val_i (LAT),
        .dec_i      (state_q == WAIT),
        .one_o      (lat_one)
    );

    assign if_done = (state_q == DONE) && (owner_q == OWNER_IF);
    assign d_done  = (state_q == DONE) && (owner_q == OWNER_D);

    assign bus.if_gnt    = (state_q == ISSUE) && (owner_q == OWNER_IF);
    assign bus.d_gnt     = (state_q == ISSUE) && (owner_q == OWNER_D);
    assign bus.if_rvalid = if_done;
    assign bus.d_rvalid  = d_done;
    assign bus.if_rdata  = if_done ? rdata_q : '0;
    assign bus.d_rdata   = d_done  ? rdata_q : '0;
    assign bus.mem_re    = (state_q == ISSUE) && !we_q;
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    // addr_q only changes when a new access is latched, so it is held through WAIT.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned MEM_LAT = 3;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_ready = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   gnt_cyc = 0;
    int   last_rv_cyc = 0;
    exp_t sb[$];
    vec_t vecs[8];
    bit   g_own[8];
    int   g_cyc[8];
    int   g_n;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h0000_0093;
        if (i == 1) return 32'h0010_0113;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Memory model: data valid only in the cycle MEM_LAT after the read strobe.
    logic [31:0] mem [256];
    logic [31:0] pipe_d [MEM_LAT];
    logic        pipe_v [MEM_LAT];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        pipe_v[0] <= bus.mem_re;
        pipe_d[0] <= mem[bus.mem_addr[9:2]];
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign bus.mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input int act, input int exp);
        n_total++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.if_rvalid || bus.d_rvalid) begin
                check("rvalid_exclusive", 64'(bus.if_rvalid & bus.d_rvalid), 64'd0);
                if (sb.size() == 0) begin
                    fail("rvalid_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rvalid_owner", 64'(bus.d_rvalid), 64'(e.is_d));
                    check("rdata", 64'(bus.d_rvalid ? bus.d_rdata : bus.if_rdata), 64'(e.rdata));
                    check("nonowner_rdata", 64'(bus.d_rvalid ? bus.if_rdata : bus.d_rdata), 64'd0);
                    last_rv_cyc = cyc;
                end
            end else if ((bus.if_rdata | bus.d_rdata) != 32'd0) begin
                check("idle_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
            end
        end
    end

    task automatic check_outs_zero(input string name);
        check({name, "_ctl"}, 64'({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid,
                                   bus.mem_re, bus.mem_we}), 64'd0);
        check({name, "_data"}, 64'(bus.if_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata), 64'd0);
    endtask

    task automatic do_reset();
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b1;
        check_outs_zero("reset_outs");
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail({tag, "_drain_timeout"}, sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, input string tag);
        int lat = 0;
        bit got = 0;
        exp_t e;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            got = is_d ? bus.d_gnt : bus.if_gnt;
        end
        if (!got) begin
            fail({tag, "_gnt_timeout"}, lat, 1);
            bus.d_req = 1'b0; bus.if_req = 1'b0;
        end else begin
            e.is_d = is_d; e.rdata = exp;
            sb.push_back(e);
            gnt_cyc = cyc;
            check({tag, "_gnt_lat"}, 64'(lat), 64'd1);
            check({tag, "_other_gnt"}, 64'(is_d ? bus.if_gnt : bus.d_gnt), 64'd0);
            check({tag, "_strobes"}, 64'({bus.mem_re, bus.mem_we}), we ? 64'd1 : 64'd2);
            check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(addr));
            if (we) check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(wdata));
            @(negedge clk);
            bus.d_req = 1'b0; bus.if_req = 1'b0;
            check({tag, "_wait_strobes"}, 64'({bus.mem_re, bus.mem_we}), 64'd0);
            check({tag, "_addr_held"}, 64'(bus.mem_addr), 64'(addr));
        end
        wait_drain(tag);
    endtask

    // Both ports request together; each drops req the cycle after its grant and,
    // when reraise is set, requests again one cycle later until rounds grants seen.
    task automatic contend(input int rounds, input bit reraise);
        bit if_drop = 0, d_drop = 0, if_re = 0, d_re = 0;
        int t = 0;
        exp_t e;
        g_n = 0;
        bus.if_addr = 32'h0;
        bus.d_we = 1'b0; bus.d_addr = 32'h10; bus.d_wdata = '0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        while (t < 300 && (bus.if_req || bus.d_req || if_drop || d_drop || if_re || d_re)) begin
            @(negedge clk);
            t++;
            if (if_drop) begin
                bus.if_req = 1'b0; if_drop = 0; if_re = reraise && (g_n < rounds);
            end else if (if_re) begin
                bus.if_req = 1'b1; if_re = 0;
            end
            if (d_drop) begin
                bus.d_req = 1'b0; d_drop = 0; d_re = reraise && (g_n < rounds);
            end else if (d_re) begin
                bus.d_req = 1'b1; d_re = 0;
            end
            if (bus.if_gnt) begin
                if (g_n < 8) begin g_own[g_n] = OWNER_IF; g_cyc[g_n] = cyc; end
                g_n++;
                e.is_d = 1'b0; e.rdata = init_word(0);
                sb.push_back(e);
                if_drop = 1;
            end
            if (bus.d_gnt) begin
                if (g_n < 8) begin g_own[g_n] = OWNER_D; g_cyc[g_n] = cyc; end
                g_n++;
                e.is_d = 1'b1; e.rdata = init_word(4);
                sb.push_back(e);
                d_drop = 1;
            end
        end
        if (t >= 300) begin
            fail("contend_timeout", t, 0);
            bus.if_req = 1'b0; bus.d_req = 1'b0;
        end
        wait_drain("contend");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit exp_own;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        vecs[0] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h4,   32'h0,         32'h0010_0113};
        vecs[3] = '{1'b1, 1'b1, 32'h8,   32'h1234_5678, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h8,   32'h0,         32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h3FC, 32'h0,         32'hC0DE_00FF};
        vecs[6] = '{1'b1, 1'b1, 32'h3FC, 32'hFFFF_FFFF, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h3FC, 32'h0,         32'hFFFF_FFFF};

        @(negedge clk);
        do_reset();

        // Single fetch from address 0: grant one cycle after req, data MEM_LAT+1 after grant.
        issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0093, "fetch0");
        check("fetch0_rvalid_lat", 64'(last_rv_cyc - gnt_cyc), 64'(MEM_LAT + 1));

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end
        check("store_mem_content", 64'(mem[64]), 64'hDEAD_BEEF);

        // Reset asserted during WAIT of a load: access dropped, no rvalid afterwards.
        begin
            int n = 0;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
            while (!bus.d_gnt && n < 50) begin @(negedge clk); n++; end
            if (!bus.d_gnt) fail("rstwait_gnt_timeout", n, 1);
            @(negedge clk);
            bus.d_req = 1'b0;
            rst_n = 1'b0;
            #1;
            check_outs_zero("rstwait_outs");
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            seen = 0;
            repeat (MEM_LAT + 4) begin
                @(negedge clk);
                seen = seen | bus.d_rvalid | bus.if_rvalid;
            end
            check("rstwait_no_rvalid", 64'(seen), 64'd0);
        end
        issue(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, "after_rst");

        // Simultaneous pair after reset: D first, IF follows MEM_LAT+2 later.
        do_reset();
        contend(2, 1'b0);
        check("pair_count", 64'(g_n), 64'd2);
        check("pair_first", 64'(g_own[0]), 64'(OWNER_D));
        check("pair_second", 64'(g_own[1]), 64'(OWNER_IF));
        check("pair_spacing", 64'(g_cyc[1] - g_cyc[0]), 64'(MEM_LAT + 2));

        // Continuous requests from both ports.
        do_reset();
        contend(4, 1'b1);
        check("stream_count", 64'(g_n), 64'd5);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_own = (k % 2 == 0) ? OWNER_D : OWNER_IF;
`else
            exp_own = OWNER_D;
`endif
            check($sformatf("stream_owner%0d", k), 64'(g_own[k]), 64'(exp_own));
            if (k > 0) check($sformatf("stream_spacing%0d", k), 64'(g_cyc[k] - g_cyc[k-1]),
                             64'(MEM_LAT + 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
